// File: rtl/compare_seq_pkg.sv
// Shared definitions for the compare sequencer: FSM state encodings,
// result bit positions and the signed-mode switch code.
package compare_seq_pkg;

  typedef enum logic [1:0] {
    ST_A    = 2'b00,
    ST_B    = 2'b01,
    ST_CMP  = 2'b10,
    ST_SHOW = 2'b11
  } state_e;

  localparam int unsigned RES_EQ = 2;
  localparam int unsigned RES_GT = 1;
  localparam int unsigned RES_LT = 0;

  localparam logic [1:0] SIGNED_MODE = 2'b11;

endpackage

// File: rtl/compare_sequencer_key_pulse.sv
// Active-low push-button to one-cycle press pulse: 2-flop synchronizer,
// optional debounce counter, falling-edge detect.
// Build option: COMPARE_SEQ_DEBOUNCE_EN enables the debounce counter.
module key_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic pulse_o
);

  // A zero-cycle debounce window has no meaning.
  if (DEBOUNCE_CYCLES == 0) begin : g_param_check
    $error("key_pulse: DEBOUNCE_CYCLES must be non-zero");
  end

  logic sync1_q, sync2_q;
  logic pulse_q, pulse_d;

  // Synchronizer; reset to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef COMPARE_SEQ_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive low samples, saturating; fire once on reaching the limit.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d   = cnt_q + 1'b1;
      pulse_d = (cnt_d == CntMax);
    end
  end

  // Debounce counter and registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
`else
  logic prev_q;

  // Falling edge of the synchronized key.
  always_comb begin
    pulse_d = prev_q & ~sync2_q;
  end

  // Edge-detect history and registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= sync2_q;
      pulse_q <= pulse_d;
    end
  end
`endif

  assign pulse_o = pulse_q;

endmodule

// File: rtl/compare_sequencer.sv
// Button-driven sequencer for a 4-bit comparator: latch A, latch B and mode,
// compare in one registered step, then hold the result until re-armed.
// Build option: COMPARE_SEQ_DEBOUNCE_EN enables key debouncing in key_pulse.
module compare_sequencer
  import compare_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_sw,
  input  logic [1:0] mode_sw,
  input  logic       key_enter_n,
  input  logic       key_clear_n,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [3:0] mag_a,
  output logic [3:0] mag_b,
  output logic       neg_a,
  output logic       neg_b,
  output logic [2:0] result,
  output logic       result_valid,
  output logic [1:0] state_led
);

  logic enter_p, clear_p;

  key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_enter_n),
    .pulse_o (enter_p)
  );

  key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_clear_n),
    .pulse_o (clear_p)
  );

  state_e     state_q;
  logic [3:0] op_a_q, op_b_q;
  logic       mode_q;
  logic [2:0] result_q;
  logic       result_valid_q;

  logic signed [4:0] val_a, val_b;
  logic [2:0]        cmp_res;

  // Extend operands to 5-bit signed so one comparator serves both modes.
  always_comb begin
    val_a   = {mode_q & op_a_q[3], op_a_q};
    val_b   = {mode_q & op_b_q[3], op_b_q};
    cmp_res = '0;
    if (val_a == val_b) begin
      cmp_res[RES_EQ] = 1'b1;
    end else if (val_a > val_b) begin
      cmp_res[RES_GT] = 1'b1;
    end else begin
      cmp_res[RES_LT] = 1'b1;
    end
  end

  // Display magnitude/sign; -8 wraps to 4'h8 naturally.
  always_comb begin
    neg_a = mode_q & op_a_q[3];
    neg_b = mode_q & op_b_q[3];
    mag_a = neg_a ? (~op_a_q + 4'd1) : op_a_q;
    mag_b = neg_b ? (~op_b_q + 4'd1) : op_b_q;
  end

  // Sequencer FSM with operand, mode and result registers; clear beats enter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      mode_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (clear_p) begin
      state_q        <= ST_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      mode_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_A: begin
          if (enter_p) begin
            op_a_q  <= data_sw;
            state_q <= ST_B;
          end
        end
        ST_B: begin
          if (enter_p) begin
            op_b_q  <= data_sw;
            mode_q  <= (mode_sw == SIGNED_MODE);
            state_q <= ST_CMP;
          end
        end
        ST_CMP: begin
          result_q       <= cmp_res;
          result_valid_q <= 1'b1;
          state_q        <= ST_SHOW;
        end
        ST_SHOW: begin
          if (enter_p) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            state_q        <= ST_A;
          end
        end
        default: state_q <= ST_A;
      endcase
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state_led    = state_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Scoreboard bench for compare_sequencer (default build, no debounce).
module tb_compare_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_sw;
  logic [1:0] mode_sw;
  logic       key_enter_n, key_clear_n;
  logic [3:0] op_a, op_b, mag_a, mag_b;
  logic       neg_a, neg_b;
  logic [2:0] result;
  logic       result_valid;
  logic [1:0] state_led;

  compare_sequencer #(.DEBOUNCE_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_sw      (data_sw),
    .mode_sw      (mode_sw),
    .key_enter_n  (key_enter_n),
    .key_clear_n  (key_clear_n),
    .op_a         (op_a),
    .op_b         (op_b),
    .mag_a        (mag_a),
    .mag_b        (mag_b),
    .neg_a        (neg_a),
    .neg_b        (neg_b),
    .result       (result),
    .result_valid (result_valid),
    .state_led    (state_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] res;
    int         tgt;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: phase 0 = awaiting A, 1 = awaiting B, 2 = showing.
  int         phase;
  logic [3:0] m_a, m_b;
  bit         m_mode;
  logic [2:0] m_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input logic [3:0] v, input bit md);
    if (md && v >= 8) return int'(v) - 16;
    return int'(v);
  endfunction

  function automatic logic [3:0] magf(input logic [3:0] v, input bit md);
    int s = sval(v, md);
    if (s < 0) s = -s;
    return s[3:0];
  endfunction

  function automatic logic [2:0] cmpf(input logic [3:0] a, input logic [3:0] b, input bit md);
    int sa = sval(a, md);
    int sb = sval(b, md);
    if (sa == sb) return 3'b100;
    if (sa > sb) return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    phase  = 0;
    m_a    = '0;
    m_b    = '0;
    m_mode = 1'b0;
    m_res  = '0;
  endtask

  task automatic check_state();
    chk("state_led", 32'(state_led), (phase == 0) ? 0 : (phase == 1) ? 1 : 3);
    chk("op_a", 32'(op_a), 32'(m_a));
    chk("op_b", 32'(op_b), 32'(m_b));
    chk("mag_a", 32'(mag_a), 32'(magf(m_a, m_mode)));
    chk("mag_b", 32'(mag_b), 32'(magf(m_b, m_mode)));
    chk("neg_a", 32'(neg_a), 32'(sval(m_a, m_mode) < 0));
    chk("neg_b", 32'(neg_b), 32'(sval(m_b, m_mode) < 0));
    chk("valid", 32'(result_valid), 32'(phase == 2));
    chk("result", 32'(result), (phase == 2) ? 32'(m_res) : 0);
  endtask

  // Press one or both keys for `hold` cycles, update the model, then settle and check.
  task automatic press(input bit en, input bit cl, input int hold);
    exp_t e;
    @(negedge clk);
    key_enter_n = !en;
    key_clear_n = !cl;
    if (cl) begin
      model_reset();
    end else if (en) begin
      case (phase)
        0: begin
          m_a   = data_sw;
          phase = 1;
        end
        1: begin
          m_b    = data_sw;
          m_mode = (mode_sw == 2'b11);
          m_res  = cmpf(m_a, m_b, m_mode);
          e.res  = m_res;
          e.tgt  = cyc + 5;
          exp_q.push_back(e);
          phase  = 2;
        end
        default: begin
          m_res = '0;
          phase = 0;
        end
      endcase
    end
    repeat (hold) @(negedge clk);
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (8) @(negedge clk);
    check_state();
  endtask

  task automatic run_seq(input logic [3:0] a, input logic [3:0] b, input logic [1:0] md);
    mode_sw = md;
    data_sw = a;
    press(1'b1, 1'b0, 2);
    data_sw = b;
    press(1'b1, 1'b0, 2);
  endtask

  // Monitor: pop expected result on every rising result_valid, check latency and value.
  bit prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (result_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(result_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 32'(cyc), 32'(e.tgt));
          chk("mon_result", 32'(result), 32'(e.res));
        end
      end
      if (result_valid) chk("onehot", 32'($onehot(result)), 1);
      else chk("idle_zero", 32'(result), 0);
      prev_v = result_valid;
    end
  end

  initial begin
    rst         = 1'b1;
    data_sw     = '0;
    mode_sw     = '0;
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    model_reset();
    #1;
    chk("rst_state", 32'(state_led), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_op_a", 32'(op_a), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unsigned gt
    run_seq(4'd9, 4'd3, 2'b00);
    chk("ugt_result", 32'(result), 3'b010);
    chk("ugt_mag_a", 32'(mag_a), 9);
    chk("ugt_neg_a", 32'(neg_a), 0);
    press(1'b1, 1'b0, 2);

    // Signed lt
    run_seq(4'h9, 4'h3, 2'b11);
    chk("slt_result", 32'(result), 3'b001);
    chk("slt_neg_a", 32'(neg_a), 1);
    chk("slt_mag_a", 32'(mag_a), 7);
    chk("slt_mag_b", 32'(mag_b), 3);
    press(1'b1, 1'b0, 2);

    // Signed edge values
    run_seq(4'h8, 4'h8, 2'b11);
    chk("s88_result", 32'(result), 3'b100);
    chk("s88_mag_a", 32'(mag_a), 8);
    press(1'b1, 1'b0, 2);
    run_seq(4'h8, 4'h7, 2'b11);
    chk("s87_result", 32'(result), 3'b001);
    press(1'b1, 1'b0, 2);

    // Clear mid-sequence, then clear together with enter in ST_B
    data_sw = 4'd5;
    press(1'b1, 1'b0, 2);
    chk("clr_pre_state", 32'(state_led), 1);
    press(1'b0, 1'b1, 2);
    chk("clr_state", 32'(state_led), 0);
    chk("clr_op_a", 32'(op_a), 0);
    press(1'b1, 1'b0, 2);
    data_sw = 4'd12;
    press(1'b1, 1'b1, 2);
    chk("clrent_state", 32'(state_led), 0);
    chk("clrent_op_b", 32'(op_b), 0);

    // Mode toggle while showing, then reset mid-operation
    run_seq(4'd2, 4'd9, 2'b00);
    mode_sw = 2'b11;
    repeat (4) @(negedge clk);
    chk("toggle_result", 32'(result), 3'b001);
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state_led), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_valid", 32'(result_valid), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Long hold gives a single transition
    data_sw = 4'd6;
    press(1'b1, 1'b0, 100);
    chk("hold_state", 32'(state_led), 1);

    // Random sequences
    for (int i = 0; i < 60; i++) begin
      int op;
      op      = $urandom_range(0, 9);
      data_sw = 4'($urandom);
      mode_sw = 2'($urandom);
      if (op <= 7) press(1'b1, 1'b0, $urandom_range(1, 6));
      else if (op == 8) press(1'b0, 1'b1, $urandom_range(1, 6));
      else press(1'b1, 1'b1, $urandom_range(1, 6));
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/compare_sequencer.md
Name: compare_sequencer

Overview:
- Sequencing controller for the board-level 4-bit magnitude/two's-complement comparator datapath (switch operands, LEDR result, HEX display).
- Replaces direct switch-to-compare wiring: the user enters operand A, then operand B, on one 4-bit switch field using a push-button. The block latches the mode, performs a registered compare, and holds the result for display until re-armed.
- Sits between the board I/O (SW, KEY) and the seven-segment/LED drivers.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of stable-low clock cycles required to accept a press (10 ms at 50 MHz); used only when COMPARE_SEQ_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data_sw  in  4  operand value switches (SW[3:0]).
- mode_sw  in  2  mode switches (SW[9:8]); 2'b11 selects signed mode, any other value selects unsigned mode.
- key_enter_n  in  1  enter button, active-low, asynchronous to clk (KEY[0]).
- key_clear_n  in  1  clear button, active-low, asynchronous to clk (KEY[1]).
- op_a  out  4  latched raw operand A.
- op_b  out  4  latched raw operand B.
- mag_a  out  4  magnitude of A for HEX display.
- mag_b  out  4  magnitude of B for HEX display.
- neg_a  out  1  A is negative; drives the minus segment.
- neg_b  out  1  B is negative; drives the minus segment.
- result  out  3  {eq, gt, lt}; one-hot when valid.
- result_valid  out  1  result is current.
- state_led  out  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset (asynchronous, active-high): state is ST_A. op_a, op_b, result and the latched mode are 0. result_valid is 0. Synchronizer flops are 1 (button released).
- Button path: each key goes through a 2-flop synchronizer and then falling-edge detection, giving a one-cycle pulse (enter_p / clear_p).
  - Without the debounce feature, the pulse asserts on the 3rd rising clk edge after the pin is first sampled low.
  - Holding a key yields exactly one pulse.
- FSM states and encodings: ST_A = 00, ST_B = 01, ST_CMP = 10, ST_SHOW = 11. state_led equals the encoding.
  - ST_A: on enter_p, op_a <= data_sw and go to ST_B.
  - ST_B: on enter_p, op_b <= data_sw, mode_q <= (mode_sw == 2'b11), and go to ST_CMP.
  - ST_CMP: unconditional, one cycle. result is registered from op_a, op_b and mode_q; go to ST_SHOW.
  - ST_SHOW: result_valid = 1; result holds. On enter_p, go to ST_A and clear result_valid and result. op_a and op_b are kept until overwritten.
- Clear: clear_p in any state goes to ST_A and zeroes op_a, op_b, result, result_valid and mode_q. If clear_p and enter_p occur in the same cycle, clear wins and enter is discarded.
- Latency: result_valid rises 2 clk cycles after the enter_p that loads B.
- Mode handling: mode_sw changes after B is loaded have no effect until the next sequence.
- Arithmetic:
  - Unsigned mode: 0–15 compare. neg_x = 0 and mag_x = op_x.
  - Signed mode: 4-bit two's complement, range -8..7. neg_x = op_x[3]. mag_x = neg_x ? (~op_x + 1) : op_x, computed in 4 bits, so -8 gives mag 8 (4'h8).
  - The compare is a true signed compare: 4'h8 < 4'hF < 4'h0 < 4'h7.
- mag/neg outputs are combinational from the op registers and mode_q. They are valid in every state, with mode_q = 0 before B is loaded.
- Exactly one result bit is set whenever result_valid = 1; result is 3'b000 otherwise.

Optional Feature:
- Macro: COMPARE_SEQ_DEBOUNCE_EN.
- Defined: after synchronization, each key feeds a saturating counter that resets on any high sample. The press pulse asserts once, when the counter reaches DEBOUNCE_CYCLES consecutive low samples. A new press is accepted only after at least one high sample. Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined: no counter; the pulse comes directly from the synchronized falling edge. DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package compare_seq_pkg:
  - state encodings ST_A/ST_B/ST_CMP/ST_SHOW;
  - result bit indices RES_EQ = 2, RES_GT = 1, RES_LT = 0;
  - SIGNED_MODE = 2'b11.
- Sub-module key_pulse (one instance per key): synchronizer, optional debounce and edge detect. Single-bit in, single-bit pulse out, with a DEBOUNCE_CYCLES parameter.
- The FSM, operand registers and compare logic stay in compare_sequencer.

Test Plan:
- Unsigned gt: mode 00; enter A = 9, enter B = 3 → 2 cycles after the B pulse, result = 010, result_valid = 1, mag_a = 9, neg_a = 0.
- Signed lt: mode 11; A = 4'h9, B = 4'h3 → result = 001, neg_a = 1, mag_a = 7, neg_b = 0, mag_b = 3.
- Signed edge values: A = 4'h8, B = 4'h8 → result = 100, mag_a = 8. Then re-arm with A = 4'h8, B = 4'h7 → result = 001.
- Clear mid-sequence: load A = 5 (state 01), pulse clear → state 00, op_a = 0. Pulse clear together with enter in ST_B → state 00, op_b unchanged at 0.
- Reset mid-operation: assert rst in ST_SHOW → immediately state 00, result = 000, result_valid = 0. Mode_sw toggled during ST_SHOW → result unchanged.
- Debounce (macro on, DEBOUNCE_CYCLES = 8): 5-cycle low glitch → no state change. 12-cycle hold → exactly one transition. Holding for 100 cycles → still one transition.
